// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: single-entry valid/ready stage holding the ALU result,
// branch decision and control bits, plus status flags and forwarding/hazard info.
module ex_mem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [REG_W-1:0]  rd,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              set_flags,
    input  logic [1:0]        branch_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [DATA_W-1:0] out_branch_target,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              branch_taken,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    output logic              fwd_en,
    output logic              load_use_hazard
);

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_store_data;
    logic [DATA_W-1:0] r_branch_target;
    logic [REG_W-1:0]  r_rd;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_taken;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_flag_v;

    logic              w_capture;
    logic              w_taken;

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    // BLT: sign of the true difference is result MSB corrected by overflow
    always_comb begin
        w_taken = 1'b0;
        case (branch_type)
            2'b01:   w_taken = alu_zero;
            2'b10:   w_taken = !alu_zero;
            2'b11:   w_taken = alu_result[DATA_W-1] ^ alu_overflow;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid         <= 1'b0;
            r_result        <= '0;
            r_store_data    <= '0;
            r_branch_target <= '0;
            r_rd            <= '0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_taken         <= 1'b0;
            r_flag_z        <= 1'b0;
            r_flag_c        <= 1'b0;
            r_flag_v        <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid         <= 1'b1;
            r_result        <= alu_result;
            r_store_data    <= store_data;
            r_branch_target <= branch_target;
            r_rd            <= rd;
            r_reg_write     <= reg_write;
            r_mem_read      <= mem_read;
            r_mem_write     <= mem_write;
            r_taken         <= w_taken;
            if (set_flags) begin
                r_flag_z <= alu_zero;
                r_flag_c <= alu_carry;
                r_flag_v <= alu_overflow;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid         = r_valid;
    assign out_result        = r_result;
    assign out_store_data    = r_store_data;
    assign out_branch_target = r_branch_target;
    assign out_rd            = r_rd;
    assign out_reg_write     = r_reg_write;
    assign out_mem_read      = r_mem_read;
    assign out_mem_write     = r_mem_write;
    assign branch_taken      = r_taken;
    assign flag_z            = r_flag_z;
    assign flag_c            = r_flag_c;
    assign flag_v            = r_flag_v;

    // Register 0 is hardwired, so it never forwards nor causes a stall
    assign fwd_en = r_valid && r_reg_write && !r_mem_read && (r_rd != '0);
    assign load_use_hazard = r_valid && r_mem_read && (r_rd != '0) &&
                             ((r_rd == id_rs) || (r_rd == id_rt));

endmodule
